// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side FIFO for a UART. Words arriving with Data_Rdy are queued in a
// circular buffer and handed out one per Read_Req with a single cycle of
// latency. Occupancy and level flags are always visible. Overflow and
// underflow events are latched until software clears them.
//
// Parameters
//   DATA_BITS   width of each stored word
//   FIFO_DEPTH  number of entries (power of two, >= 2)
//   AFULL_LVL   Almost_Full when Count >= AFULL_LVL
//   AEMPTY_LVL  Almost_Empty when Count <= AEMPTY_LVL
//
// Ports
//   Clk            rising-edge clock
//   Rst            asynchronous, active-high reset
//   Rx_Data        word to enqueue
//   Data_Rdy       write strobe
//   Read_Req       read strobe
//   Flush          synchronous empty command (drops same-cycle read/write)
//   Clr_Err        clears FIFO_Overflow / FIFO_Underflow
//   BIST_Mode      while high, Data_Rdy is ignored
//   Data_Out       registered read data, held until the next accepted read
//   Data_Valid     one-cycle pulse qualifying Data_Out
//   Count          current occupancy (0..FIFO_DEPTH)
//   FIFO_Empty, FIFO_Full, Almost_Empty, Almost_Full   level flags
//   FIFO_Overflow, FIFO_Underflow                      sticky error flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_LVL  = 12,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [DATA_BITS-1:0]          Rx_Data,
    input  logic                          Data_Rdy,
    input  logic                          Read_Req,
    input  logic                          Flush,
    input  logic                          Clr_Err,
    input  logic                          BIST_Mode,
    output logic [DATA_BITS-1:0]          Data_Out,
    output logic                          Data_Valid,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          FIFO_Empty,
    output logic                          FIFO_Full,
    output logic                          Almost_Empty,
    output logic                          Almost_Full,
    output logic                          FIFO_Overflow,
    output logic                          FIFO_Underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Storage is deliberately left without reset so it can map onto RAM.
    logic [DATA_BITS-1:0] mem_reg [FIFO_DEPTH];

    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 data_valid_reg;
    logic                 overflow_reg;
    logic                 underflow_reg;

    // Cleared by reset and set on the first clock edge that sees Rst low.
    // Gating every operation with it guarantees that the edge on which reset
    // is released never accepts a read, write or flush, whichever way the
    // Rst/Clk race resolves.
    logic                 run_reg;

    logic full_now;
    logic empty_now;
    logic flush_now;
    logic wr_attempt;
    logic wr_accept;
    logic rd_accept;
    logic ovf_event;
    logic udf_event;

    always_comb begin
        full_now   = (count_reg == DEPTH_C);
        empty_now  = (count_reg == '0);
        flush_now  = run_reg & Flush;
        wr_attempt = run_reg & Data_Rdy & ~BIST_Mode & ~Flush;
        rd_accept  = run_reg & Read_Req & ~Flush & ~empty_now;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_accept  = wr_attempt & (~full_now | rd_accept);
        ovf_event  = wr_attempt & full_now & ~rd_accept;
        udf_event  = run_reg & Read_Req & ~Flush & empty_now;

        count_next = count_reg;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Write port. When full with a simultaneous read, wr_ptr equals rd_ptr;
    // the read below samples the old word before this write lands.
    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            mem_reg[wr_ptr_reg] <= Rx_Data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run_reg        <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            run_reg        <= 1'b1;
            data_valid_reg <= rd_accept;

            if (flush_now) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_accept) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
                if (rd_accept) begin
                    rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                    data_out_reg <= mem_reg[rd_ptr_reg];
                end
                count_reg <= count_next;
            end

            // A new event wins over a same-cycle clear.
            overflow_reg  <= ovf_event | (overflow_reg  & ~Clr_Err);
            underflow_reg <= udf_event | (underflow_reg & ~Clr_Err);
        end
    end

    assign Data_Out       = data_out_reg;
    assign Data_Valid     = data_valid_reg;
    assign Count          = count_reg;
    assign FIFO_Empty     = empty_now;
    assign FIFO_Full      = full_now;
    assign Almost_Full    = (count_reg >= AFULL_C);
    assign Almost_Empty   = (count_reg <= AEMPTY_C);
    assign FIFO_Overflow  = overflow_reg;
    assign FIFO_Underflow = underflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo with default parameters. A queue-based
// reference model tracks the stored words, the expected read data and the
// sticky error flags. Directed scenarios cover the basic path, overflow,
// full read+write across pointer wrap, underflow/BIST, level flags, flush and
// asynchronous reset; a randomized run closes it out.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DB-1:0] Rx_Data = '0;
    logic          Data_Rdy = 1'b0;
    logic          Read_Req = 1'b0;
    logic          Flush = 1'b0;
    logic          Clr_Err = 1'b0;
    logic          BIST_Mode = 1'b0;
    logic [DB-1:0] Data_Out;
    logic          Data_Valid;
    logic [4:0]    Count;
    logic          FIFO_Empty, FIFO_Full, Almost_Empty, Almost_Full;
    logic          FIFO_Overflow, FIFO_Underflow;

    uart_rx_fifo #(
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH),
        .AFULL_LVL (AF),
        .AEMPTY_LVL(AE)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Rx_Data       (Rx_Data),
        .Data_Rdy      (Data_Rdy),
        .Read_Req      (Read_Req),
        .Flush         (Flush),
        .Clr_Err       (Clr_Err),
        .BIST_Mode     (BIST_Mode),
        .Data_Out      (Data_Out),
        .Data_Valid    (Data_Valid),
        .Count         (Count),
        .FIFO_Empty    (FIFO_Empty),
        .FIFO_Full     (FIFO_Full),
        .Almost_Empty  (Almost_Empty),
        .Almost_Full   (Almost_Full),
        .FIFO_Overflow (FIFO_Overflow),
        .FIFO_Underflow(FIFO_Underflow)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DB-1:0] q[$];
    logic [DB-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_udf;

    task automatic model_clear();
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // Drive one cycle of inputs, let the rising edge happen, advance the model
    // by the FIFO rules, and return 1 time unit after the edge.
    task automatic tick(input logic dr, input logic rr, input logic fl,
                        input logic ce, input logic bist, input logic [DB-1:0] din);
        int n;
        bit rd, wr, oe, ue;
        Data_Rdy  = dr;
        Read_Req  = rr;
        Flush     = fl;
        Clr_Err   = ce;
        BIST_Mode = bist;
        Rx_Data   = din;
        @(posedge Clk);
        n  = q.size();
        rd = rr && !fl && (n > 0);
        wr = dr && !bist && !fl && ((n < DEPTH) || rd);
        oe = dr && !bist && !fl && (n == DEPTH) && !rd;
        ue = rr && !fl && (n == 0);
        exp_valid = rd;
        if (rd) exp_dout = q.pop_front();
        if (fl) q.delete();
        if (wr) q.push_back(din);
        exp_ovf = oe || (exp_ovf && !ce);
        exp_udf = ue || (exp_udf && !ce);
        #1;
        if (wr || rd || fl)
            $display("txn @%0t wr=%0b din=%h rd=%0b dout=%h flush=%0b level=%0d",
                     $time, wr, din, rd, exp_dout, fl, q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Data_Rdy = 0; Read_Req = 0; Flush = 0; Clr_Err = 0; BIST_Mode = 0;
        #2;
        checks++;
        if ({Count, FIFO_Empty, Almost_Empty, FIFO_Full, Almost_Full} !== {5'd0, 4'b1100}) begin
            errors++;
            $display("FAIL reset_levels: got cnt=%0d e/ae/f/af=%b required cnt=0 e/ae/f/af=1100",
                     Count, {FIFO_Empty, Almost_Empty, FIFO_Full, Almost_Full});
        end
        checks++;
        if ({Data_Out, Data_Valid, FIFO_Overflow, FIFO_Underflow} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%h v=%b ovf=%b udf=%b required all zero",
                     Data_Out, Data_Valid, FIFO_Overflow, FIFO_Underflow);
        end
        model_clear();
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [DB-1:0] words [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, words[i]);
        checks++;
        if (Count !== 5'd3) begin
            errors++;
            $display("FAIL basic_count3: got %0d required 3", Count);
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0, '0);
            checks++;
            if (Data_Valid !== 1'b1 || Data_Out !== words[i]) begin
                errors++;
                $display("FAIL basic_read%0d: got v=%b dout=%h required v=1 dout=%h",
                         i, Data_Valid, Data_Out, words[i]);
            end
        end
        tick(0, 0, 0, 0, 0, '0);
        checks++;
        if (Data_Valid !== 1'b0 || Data_Out !== 8'h33 || Count !== 5'd0 || FIFO_Empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_after: got v=%b dout=%h cnt=%0d empty=%b required v=0 dout=33 cnt=0 empty=1",
                     Data_Valid, Data_Out, Count, FIFO_Empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) tick(1, 0, 0, 0, 0, 8'(8'hA0 + i));
        checks++;
        if (FIFO_Full !== 1'b1 || Count !== 5'd16 || FIFO_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill16: got full=%b cnt=%0d ovf=%b required full=1 cnt=16 ovf=0",
                     FIFO_Full, Count, FIFO_Overflow);
        end
        tick(1, 0, 0, 0, 0, 8'hEE);
        checks++;
        if (FIFO_Full !== 1'b1 || Count !== 5'd16 || FIFO_Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_17th: got full=%b cnt=%0d ovf=%b required full=1 cnt=16 ovf=1",
                     FIFO_Full, Count, FIFO_Overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 1, 0, 0, 0, '0);
            checks++;
            if (Data_Valid !== 1'b1 || Data_Out !== 8'(8'hA0 + i)) begin
                errors++;
                $display("FAIL ovf_read%0d: got v=%b dout=%h required v=1 dout=%h",
                         i, Data_Valid, Data_Out, 8'(8'hA0 + i));
            end
        end
        checks++;
        if (Count !== 5'd0 || FIFO_Overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained: got cnt=%0d ovf=%b required cnt=0 ovf=1", Count, FIFO_Overflow);
        end
        tick(0, 0, 0, 1, 0, '0);
        checks++;
        if (FIFO_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", FIFO_Overflow);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) tick(1, 0, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            tick(1, 1, 0, 0, 0, 8'($urandom));
            checks++;
            if (Data_Valid !== 1'b1 || Data_Out !== exp_dout || Count !== 5'd16 ||
                FIFO_Full !== 1'b1 || FIFO_Overflow !== 1'b0) begin
                errors++;
                $display("FAIL fullrw_%0d: got v=%b dout=%h cnt=%0d full=%b ovf=%b required v=1 dout=%h cnt=16 full=1 ovf=0",
                         i, Data_Valid, Data_Out, Count, FIFO_Full, FIFO_Overflow, exp_dout);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 1, 0, 0, 0, '0);
            checks++;
            if (Data_Valid !== 1'b1 || Data_Out !== exp_dout) begin
                errors++;
                $display("FAIL fullrw_drain%0d: got v=%b dout=%h required v=1 dout=%h",
                         i, Data_Valid, Data_Out, exp_dout);
            end
        end
        checks++;
        if (FIFO_Empty !== 1'b1) begin
            errors++;
            $display("FAIL fullrw_empty: got %b required 1", FIFO_Empty);
        end
    endtask

    task automatic test_underflow_bist();
        logic [DB-1:0] held;
        held = exp_dout;
        tick(0, 1, 0, 0, 0, '0);
        checks++;
        if (FIFO_Underflow !== 1'b1 || Data_Valid !== 1'b0 || Data_Out !== held) begin
            errors++;
            $display("FAIL udf_set: got udf=%b v=%b dout=%h required udf=1 v=0 dout=%h",
                     FIFO_Underflow, Data_Valid, Data_Out, held);
        end
        tick(0, 0, 0, 1, 0, '0);
        checks++;
        if (FIFO_Underflow !== 1'b0 || Data_Valid !== 1'b0) begin
            errors++;
            $display("FAIL udf_clear: got udf=%b v=%b required udf=0 v=0", FIFO_Underflow, Data_Valid);
        end
        tick(0, 1, 0, 1, 0, '0);
        checks++;
        if (FIFO_Underflow !== 1'b1) begin
            errors++;
            $display("FAIL udf_clr_vs_event: got %b required 1", FIFO_Underflow);
        end
        tick(0, 0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 1, 8'($urandom));
        checks++;
        if (Count !== 5'd0 || FIFO_Overflow !== 1'b0 || FIFO_Underflow !== 1'b0) begin
            errors++;
            $display("FAIL bist_block: got cnt=%0d ovf=%b udf=%b required cnt=0 ovf=0 udf=0",
                     Count, FIFO_Overflow, FIFO_Underflow);
        end
        tick(1, 1, 0, 0, 0, 8'h5A);
        checks++;
        if (Count !== 5'd1 || FIFO_Underflow !== 1'b1 || Data_Valid !== 1'b0) begin
            errors++;
            $display("FAIL udf_with_write: got cnt=%0d udf=%b v=%b required cnt=1 udf=1 v=0",
                     Count, FIFO_Underflow, Data_Valid);
        end
        tick(0, 1, 0, 1, 0, '0);
        checks++;
        if (Data_Valid !== 1'b1 || Data_Out !== 8'h5A || FIFO_Underflow !== 1'b0) begin
            errors++;
            $display("FAIL udf_readback: got v=%b dout=%h udf=%b required v=1 dout=5a udf=0",
                     Data_Valid, Data_Out, FIFO_Underflow);
        end
    endtask

    task automatic test_flags_flush();
        for (int c = 1; c <= AF; c++) begin
            tick(1, 0, 0, 0, 0, 8'($urandom));
            checks++;
            if (Count !== 5'(c) || Almost_Full !== (c >= AF) || Almost_Empty !== (c <= AE)) begin
                errors++;
                $display("FAIL level_%0d: got cnt=%0d af=%b ae=%b required cnt=%0d af=%b ae=%b",
                         c, Count, Almost_Full, Almost_Empty, c, (c >= AF), (c <= AE));
            end
        end
        tick(1, 1, 1, 0, 0, 8'h77);
        checks++;
        if (Count !== 5'd0 || FIFO_Empty !== 1'b1 || Data_Valid !== 1'b0 || Almost_Full !== 1'b0) begin
            errors++;
            $display("FAIL flush: got cnt=%0d empty=%b v=%b af=%b required cnt=0 empty=1 v=0 af=0",
                     Count, FIFO_Empty, Data_Valid, Almost_Full);
        end
        tick(0, 1, 0, 0, 0, '0);
        tick(0, 0, 1, 0, 0, '0);
        checks++;
        if (FIFO_Underflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_err: got udf=%b required 1", FIFO_Underflow);
        end
        tick(0, 0, 0, 1, 0, '0);
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 8'(8'h40 + i));
        tick(1, 1, 0, 0, 0, 8'h45);
        #2 Rst = 1'b1;
        #1;
        checks++;
        if ({Count, FIFO_Empty, Almost_Empty, FIFO_Full, Almost_Full, Data_Out, Data_Valid,
             FIFO_Overflow, FIFO_Underflow} !== {5'd0, 4'b1100, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL rst_async: got cnt=%0d flags=%b dout=%h v=%b ovf=%b udf=%b required cnt=0 flags=1100 dout=00 v=0 ovf=0 udf=0",
                     Count, {FIFO_Empty, Almost_Empty, FIFO_Full, Almost_Full}, Data_Out,
                     Data_Valid, FIFO_Overflow, FIFO_Underflow);
        end
        model_clear();
        Data_Rdy = 1'b1;
        Rx_Data  = 8'h99;
        @(posedge Clk);
        Rst = 1'b0;
        #1;
        checks++;
        if (Count !== 5'd0) begin
            errors++;
            $display("FAIL rst_release_edge: got cnt=%0d required 0", Count);
        end
        Data_Rdy = 1'b0;
        tick(1, 0, 0, 0, 0, 8'h99);
        tick(0, 1, 0, 0, 0, '0);
        checks++;
        if (Data_Valid !== 1'b1 || Data_Out !== 8'h99 || Count !== 5'd0) begin
            errors++;
            $display("FAIL rst_after: got v=%b dout=%h cnt=%0d required v=1 dout=99 cnt=0",
                     Data_Valid, Data_Out, Count);
        end
    endtask

    task automatic test_random();
        logic [23:0] got, req;
        int n;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(99) < 60, $urandom_range(99) < 50, $urandom_range(99) < 3,
                 $urandom_range(99) < 5, $urandom_range(99) < 5, 8'($urandom));
            n   = q.size();
            got = {Data_Valid, Data_Out, Count, FIFO_Empty, FIFO_Full, Almost_Empty,
                   Almost_Full, FIFO_Overflow, FIFO_Underflow, 4'b0};
            req = {exp_valid, exp_dout, 5'(n), n == 0, n == DEPTH, n <= AE, n >= AF,
                   exp_ovf, exp_udf, 4'b0};
            checks++;
            if (got !== req) begin
                errors++;
                $display("FAIL random_%0d: got v/dout/cnt/e/f/ae/af/ovf/udf=%h required %h",
                         i, got, req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_underflow_bist();
        test_flags_flush();
        test_reset_midburst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
